// File: rtl/code_entry.sv
// rtl/code_entry.sv - three-digit keypad code entry with compare and program modes
//
// Collects a digit sequence, then in one RESULT cycle either compares it with the
// stored code (unlock / lock pulse) or overwrites the stored code (programmed pulse).
// Optional feature macro: ENTRY_TIMEOUT_EN adds an inter-digit timeout of TIMEOUT_CYC cycles.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   digit_valid  in   one-cycle strobe, digit present
//   digit        in   digit value (DIGIT_W bits)
//   set          in   mode, sampled with first digit: 1 = program, 0 = compare
//   clear        in   synchronous abort of a partial entry
//   lockout      in   entry inhibited
//   unlock       out  one-cycle pulse, entered code matches stored code
//   lock         out  one-cycle pulse, mismatch or compare-mode timeout
//   programmed   out  one-cycle pulse, new code stored
//   busy         out  high while in ENTRY or RESULT
//   digit_cnt    out  digits accepted in the current sequence
module code_entry #(
    parameter int unsigned DIGIT_W     = 4,
    parameter int unsigned NUM_DIGITS  = 3,
    parameter logic [DIGIT_W*NUM_DIGITS-1:0] DEFAULT_CODE = '0,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               digit_valid,
    input  logic [DIGIT_W-1:0] digit,
    input  logic               set,
    input  logic               clear,
    input  logic               lockout,
    output logic               unlock,
    output logic               lock,
    output logic               programmed,
    output logic               busy,
    output logic [1:0]         digit_cnt
);

    localparam int unsigned CODE_W = DIGIT_W * NUM_DIGITS;
    localparam logic [1:0]  LAST_IDX = 2'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ENTRY  = 2'd1,
        S_RESULT = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          idx_q, idx_d;
    logic [CODE_W-1:0]   buf_q, buf_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                mode_q, mode_d;

`ifdef ENTRY_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TO_W-1:0]     to_q, to_d;
    logic                lock_to_q, lock_to_d;
`else
    // Without the timeout a partial entry is held indefinitely; TIMEOUT_CYC is inert.
    if (TIMEOUT_CYC == 0) begin : g_no_timeout
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            buf_q     <= '0;
            code_q    <= DEFAULT_CODE;
            mode_q    <= 1'b0;
`ifdef ENTRY_TIMEOUT_EN
            to_q      <= '0;
            lock_to_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            buf_q     <= buf_d;
            code_q    <= code_d;
            mode_q    <= mode_d;
`ifdef ENTRY_TIMEOUT_EN
            to_q      <= to_d;
            lock_to_q <= lock_to_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        buf_d      = buf_q;
        code_d     = code_q;
        mode_d     = mode_q;
        unlock     = 1'b0;
        lock       = 1'b0;
        programmed = 1'b0;
        busy       = (state_q != S_IDLE);
`ifdef ENTRY_TIMEOUT_EN
        to_d       = to_q;
        lock_to_d  = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                // clear wins over digit_valid
                if (clear) begin
                    buf_d = '0;
                    idx_d = '0;
                end else if (digit_valid && !lockout) begin
                    buf_d   = {{(CODE_W-DIGIT_W){1'b0}}, digit};
                    mode_d  = set;
                    idx_d   = 2'd1;
                    state_d = S_ENTRY;
`ifdef ENTRY_TIMEOUT_EN
                    to_d    = '0;
`endif
                end
            end
            S_ENTRY: begin
                if (clear || lockout) begin
                    state_d = S_IDLE;
                    buf_d   = '0;
                    idx_d   = '0;
                end else if (digit_valid) begin
                    // Shift in: the first digit ends up in the top nibble
                    buf_d = {buf_q[CODE_W-DIGIT_W-1:0], digit};
`ifdef ENTRY_TIMEOUT_EN
                    to_d  = '0;
`endif
                    if (idx_q == LAST_IDX) begin
                        state_d = S_RESULT;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
`ifdef ENTRY_TIMEOUT_EN
                else if (to_q == TO_W'(TIMEOUT_CYC - 1)) begin
                    // A compare-mode timeout counts as a failed trial; program mode aborts silently
                    state_d   = S_IDLE;
                    buf_d     = '0;
                    idx_d     = '0;
                    lock_to_d = !mode_q;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
`endif
            end
            S_RESULT: begin
                // Compare against the code held before this sequence's own update
                if (mode_q) begin
                    programmed = 1'b1;
                    code_d     = buf_q;
                end else if (buf_q == code_q) begin
                    unlock = 1'b1;
                end else begin
                    lock = 1'b1;
                end
                state_d = S_IDLE;
                buf_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef ENTRY_TIMEOUT_EN
        lock = lock | lock_to_q;
`endif
    end

    assign digit_cnt = idx_q;

endmodule
